l1_data_cache: RTL and testbench
================================

Name: l1_data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 cache serving the CPU's data-memory port (cmem_*_b).
- Sits between the pipeline's MEM stage and the physical-memory (or L2) port.
- Answers hits in the same cycle, so the pipeline stalls only on misses.
- Moves whole 256-bit lines to and from physical memory.

Parameters:
S_INDEX, 3, log2 of set count (default 8 sets); offset fixed at 5 bits (32-byte line); tag width = 27 - S_INDEX

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_byte_enable  input  4  byte lanes for writes
mem_address  input  32  CPU byte address; word select = addr[4:2]
mem_wdata  input  32  CPU write data, lane-aligned
mem_resp  output  1  request complete this cycle
mem_rdata  output  32  word at addr[4:2]; valid when mem_resp=1
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_address  output  32  line address, low 5 bits always 0
pmem_wdata  output  256  victim line data
pmem_resp  input  1  single-cycle pulse: pmem transaction done
pmem_rdata  input  256  fill data, valid with pmem_resp

Behaviour:
- Address split: tag = addr[31:5+S_INDEX]; index = addr[4+S_INDEX:5]; offset = addr[4:0].
- Per-set storage: valid, dirty, tag, 256-bit data.
  - Arrays read combinationally; written on rising clk.
  - reset clears only valid, dirty and FSM state; data and tag contents are don't-care.
- Reset (asynchronous, effective immediately):
  - state=IDLE; all valid=0, dirty=0.
  - mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
- hit = valid[index] & (tag[index]==tag).
- FSM states are IDLE, WRITEBACK and FILL.
- IDLE:
  - Read hit: mem_resp=1 combinationally in the same cycle; mem_rdata = word addr[4:2] of the line.
  - Write hit: mem_resp=1 same cycle. At the clk edge, bytes of word addr[4:2] with enable=1 take mem_wdata; other bytes are unchanged; dirty[index] is set to 1.
  - Write with mem_byte_enable=0: still responds and sets dirty.
  - mem_read and mem_write both high: treated as a write.
  - Miss on a clean or invalid line -> FILL next cycle.
  - Miss on a valid dirty line -> WRITEBACK next cycle.
  - mem_resp=0 on any miss cycle.
- WRITEBACK:
  - pmem_write=1; pmem_address={stored tag, index, 5'b0}; pmem_wdata = stored line.
  - All three are held stable until pmem_resp=1, then -> FILL.
- FILL:
  - pmem_read=1; pmem_address={mem_address[31:5], 5'b0}, held until pmem_resp.
  - On pmem_resp: data=pmem_rdata, tag written, valid=1, dirty=0 -> IDLE.
  - The hit is serviced in IDLE on the next cycle.
- Miss latency = (writeback cycles, if dirty) + fill cycles + 1 IDLE hit cycle.
- mem_resp is never asserted outside IDLE.
- Request dropped mid-miss (CPU flush): the current pmem transaction runs to pmem_resp and the line is installed. The CPU must keep mem_address constant while a request is pending.
- Memory side:
  - pmem_read and pmem_write are never both high.
  - Neither is asserted in IDLE.
  - pmem_resp arriving in IDLE is ignored.
- Reset mid-miss: pmem_read/pmem_write drop asynchronously; the late pmem_resp is ignored.
- mem_rdata=0 whenever mem_resp=0.

Test Plan:
1. Cold read miss, after reset, mem_read with addr 0x00000044:
   - FILL with pmem_read=1, pmem_address=0x00000040.
   - pmem_resp with rdata word1=0xDEADBEEF.
   - Next cycle mem_resp=1, mem_rdata=0xDEADBEEF.
   - pmem_write never asserted.
2. Read hit, read 0x00000048 immediately after scenario 1: mem_resp=1 in the first cycle, no pmem activity.
3. Write hit byte enable, write 0x00000044, be=4'b0011, wdata=0x12345678: same-cycle resp; subsequent read returns 0xDEAD5678; dirty set.
4. Dirty eviction, read 0x00000144 (same index 2, new tag):
   - WRITEBACK first: pmem_write=1, pmem_address=0x00000040, pmem_wdata word1=0xDEAD5678.
   - Then FILL at 0x00000140; then resp.
5. Request dropped, deassert mem_read during FILL: fill completes; line valid; later read of that address hits with no pmem traffic.
6. Reset mid-WRITEBACK, assert reset while pmem_write=1:
   - pmem_write=0 the same cycle and the stray pmem_resp is ignored.
   - Read of 0x00000144 afterwards misses and does a FILL with no writeback.

Source files
------------

// File: rtl/l1_data_cache.sv
// l1_data_cache: direct-mapped, write-back, write-allocate L1 data cache with 256-bit line transfers.
// Hits complete in the same cycle; misses run an optional WRITEBACK and then a FILL.
module l1_data_cache #(
   parameter int S_INDEX = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [3:0]   mem_byte_enable,
   input  logic [31:0]  mem_address,
   input  logic [31:0]  mem_wdata,
   output logic         mem_resp,
   output logic [31:0]  mem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic [255:0] pmem_rdata
);
   localparam int SETS = 1 << S_INDEX;
   localparam int TW = 27 - S_INDEX;
   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
   state_t state, state_next;
   logic [SETS-1:0] valid, dirty;
   logic [TW-1:0] tags [SETS];
   logic [255:0] lines [SETS];
   logic [TW-1:0] tag;
   logic [S_INDEX-1:0] index;
   logic [2:0] word;
   logic [255:0] line, merged;
   logic hit, req, fill_done, write_hit, unused_ok;
   assign tag = mem_address[31:5+S_INDEX];
   assign index = mem_address[4+S_INDEX:5];
   assign word = mem_address[4:2];
   assign unused_ok = ^mem_address[1:0];
   assign line = lines[index];
   assign hit = valid[index] && tags[index] == tag;
   assign req = mem_read || mem_write;
   assign fill_done = state == FILL && pmem_resp;
   assign write_hit = state == IDLE && mem_write && hit;
   always_comb begin
      merged = line;
      for (int b = 0; b < 4; b++)
         if (mem_byte_enable[b]) merged[32*int'(word) + 8*b +: 8] = mem_wdata[8*b +: 8];
   end
   always_comb begin
      state_next = state;
      mem_resp = 1'b0;
      mem_rdata = '0;
      pmem_read = 1'b0;
      pmem_write = 1'b0;
      pmem_address = '0;
      pmem_wdata = '0;
      case (state)
         IDLE: begin
            mem_resp = req && hit;
            mem_rdata = (req && hit) ? line[32*int'(word) +: 32] : '0;
            if (req && !hit) state_next = (valid[index] && dirty[index]) ? WRITEBACK : FILL;
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            pmem_address = {tags[index], index, 5'b0};
            pmem_wdata = line;
            if (pmem_resp) state_next = FILL;
         end
         FILL: begin
            pmem_read = 1'b1;
            pmem_address = {mem_address[31:5], 5'b0};
            if (pmem_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_next;
         if (fill_done) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
         end else if (write_hit) dirty[index] <= 1'b1;
      end
   end
   // data and tag arrays carry no reset; valid gates their use
   always_ff @(posedge clk) begin
      if (fill_done) begin
         lines[index] <= pmem_rdata;
         tags[index] <= tag;
      end else if (write_hit) lines[index] <= merged;
   end
endmodule

// File: tb/tb_l1_data_cache.sv
// tb_l1_data_cache: directed scoreboard bench for l1_data_cache with a behavioural physical-memory model.
module tb_l1_data_cache;
   logic clk = 0, reset = 1, mem_read = 0, mem_write = 0;
   logic [3:0] mem_byte_enable = 0;
   logic [31:0] mem_address = 0, mem_wdata = 0, mem_rdata, pmem_address;
   logic mem_resp, pmem_read, pmem_write, pmem_resp;
   logic [255:0] pmem_wdata, pmem_rdata = 0;
   logic resp_q = 0, stray = 0, hold = 0, both_high = 0, overlap = 0;
   int checks = 0, failures = 0, cnt = 0, rd_cnt = 0, wr_cnt = 0, cyc;
   logic [31:0] last_rd_addr = 0, last_wr_addr = 0, exp_q[$];
   logic [255:0] last_wdata = 0, pm [logic [26:0]], exp_line;
   assign pmem_resp = resp_q | stray;
   always #5 clk = ~clk;
   l1_data_cache dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );
   function automatic logic [255:0] dflt(input logic [26:0] la);
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[32*w +: 32] = {la[23:0], 5'b0, 3'(w)};
      return r;
   endfunction
   function automatic logic [255:0] line_of(input logic [26:0] la);
      return pm.exists(la) ? pm[la] : dflt(la);
   endfunction
   // memory model: answers each transaction after three request cycles
   always @(negedge clk) begin
      if (pmem_read && pmem_write) both_high = 1;
      if (mem_resp && (pmem_read || pmem_write)) overlap = 1;
      if (resp_q) resp_q = 0;
      else if ((pmem_read || pmem_write) && !hold) begin
         if (cnt == 2) begin
            cnt = 0;
            resp_q = 1;
            if (pmem_read) begin
               pmem_rdata = line_of(pmem_address[31:5]);
               rd_cnt++;
               last_rd_addr = pmem_address;
            end else begin
               pm[pmem_address[31:5]] = pmem_wdata;
               wr_cnt++;
               last_wr_addr = pmem_address;
               last_wdata = pmem_wdata;
            end
         end else cnt++;
      end else cnt = 0;
   end
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp, output int n);
      logic got = 0;
      n = 0;
      if (!wr) exp_q.push_back(exp);
      mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (mem_resp) begin
            got = 1;
            if (!wr) check("rdata", mem_rdata, exp_q.pop_front());
         end
      end
      check("resp_seen", got, 1);
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
   endtask
   initial begin
      logic [255:0] pre;
      int r0, w0;
      pre = dflt(27'h2);
      pre[63:32] = 32'hDEADBEEF;
      pre[95:64] = 32'h0BADF00D;
      pm[27'h2] = pre;
      mem_read = 1; mem_address = 32'h44;
      #12;
      check("rst_resp", mem_resp, 0);
      check("rst_rdata", mem_rdata, 0);
      check("rst_pmem_rw", {pmem_read, pmem_write}, 0);
      check("rst_paddr", pmem_address, 0);
      check("rst_pwdata", pmem_wdata, 0);
      mem_read = 0;
      @(negedge clk) reset = 0;
      @(posedge clk); #1;
      access(1, 0, 32'h44, 0, 0, 32'hDEADBEEF, cyc);
      check("cold_cycles", cyc, 5);
      check("cold_fill_addr", last_rd_addr, 32'h40);
      check("cold_rd_cnt", rd_cnt, 1);
      check("cold_no_wb", wr_cnt, 0);
      access(1, 0, 32'h48, 0, 0, 32'h0BADF00D, cyc);
      check("hit_cycles", cyc, 1);
      check("hit_no_pmem", rd_cnt, 1);
      access(0, 1, 32'h44, 4'b0011, 32'h12345678, 0, cyc);
      check("whit_cycles", cyc, 1);
      access(1, 0, 32'h44, 0, 0, 32'hDEAD5678, cyc);
      access(1, 1, 32'h4C, 4'b1100, 32'hAABBCCDD, 0, cyc);
      check("rw_as_write_cycles", cyc, 1);
      access(1, 0, 32'h4C, 0, 0, 32'hAABB0203, cyc);
      exp_line = pre;
      exp_line[63:32] = 32'hDEAD5678;
      exp_line[127:96] = 32'hAABB0203;
      access(1, 0, 32'h144, 0, 0, 32'h00000A01, cyc);
      check("evict_wb_cnt", wr_cnt, 1);
      check("evict_wb_addr", last_wr_addr, 32'h40);
      check("evict_wb_data", last_wdata, exp_line);
      check("evict_fill_addr", last_rd_addr, 32'h140);
      check("evict_cycles", cyc, 9);
      access(0, 1, 32'h164, 4'b0000, 32'hFFFFFFFF, 0, cyc);
      check("wmiss_fill_addr", last_rd_addr, 32'h160);
      access(1, 0, 32'h364, 0, 0, 32'h00001B01, cyc);
      check("be0_dirty_wb_cnt", wr_cnt, 2);
      check("be0_wb_addr", last_wr_addr, 32'h160);
      check("be0_wb_data", last_wdata, dflt(27'hB));
      r0 = rd_cnt;
      mem_read = 1; mem_address = 32'h284;
      cyc = 0;
      while (!pmem_read && cyc < 20) begin @(negedge clk); cyc++; end
      check("drop_fill_started", pmem_read, 1);
      #1 mem_read = 0;
      cyc = 0;
      while (pmem_read && cyc < 20) begin @(negedge clk); cyc++; end
      check("drop_fill_done", pmem_read, 0);
      check("drop_fill_cnt", rd_cnt, r0 + 1);
      @(posedge clk); #1;
      access(1, 0, 32'h284, 0, 0, 32'h00001401, cyc);
      check("drop_hit_cycles", cyc, 1);
      check("drop_no_pmem", rd_cnt, r0 + 1);
      access(0, 1, 32'h144, 4'b1111, 32'h11112222, 0, cyc);
      hold = 1;
      r0 = rd_cnt; w0 = wr_cnt;
      mem_read = 1; mem_address = 32'h244;
      cyc = 0;
      while (!pmem_write && cyc < 20) begin @(negedge clk); cyc++; end
      check("rwb_started", pmem_write, 1);
      check("rwb_addr", pmem_address, 32'h140);
      #1 reset = 1;
      #1;
      check("rwb_async_drop", {pmem_read, pmem_write}, 0);
      check("rwb_resp", mem_resp, 0);
      mem_read = 0;
      @(negedge clk) reset = 0;
      @(negedge clk) stray = 1;
      @(negedge clk) stray = 0;
      check("stray_ignored", {pmem_read, pmem_write, mem_resp}, 0);
      hold = 0;
      @(posedge clk); #1;
      access(1, 0, 32'h144, 0, 0, 32'h00000A01, cyc);
      check("post_rst_cycles", cyc, 5);
      check("post_rst_no_wb", wr_cnt, w0);
      check("post_rst_fill", rd_cnt, r0 + 1);
      check("post_rst_fill_addr", last_rd_addr, 32'h140);
      check("never_both_pmem", both_high, 0);
      check("no_resp_outside_idle", overlap, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
